fmul_result_stage: RTL and testbench

Result capture stage placed directly downstream of the pipelined IEEE 754 single-precision multiplier. It tracks operand pairs issued into the multiplier with a valid delay line matched to the multiplier latency, and samples the product on the correct cycle. It classifies the product (NaN/inf/zero/denormal/sign) and buffers product plus flags in a FIFO with a valid/ready output handshake. It back-pressures the issuer with credit-based `in_ready`, so results are never dropped.

---
 rtl/fmul_result_stage.sv | 109 ++++++++++
 tb/tb_fmul_result_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fmul_result_stage
// Captures fp32 multiplier products, classifies them and buffers them in a
// show-ahead FIFO with credit-based issue flow control.
// Option   : define FMUL_STICKY_FLAGS_EN to add sticky exception flags.
// Revision : 1.0
// ============================================================================
module fmul_result_stage #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            c_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [4:0]             out_flags,
`ifdef FMUL_STICKY_FLAGS_EN
    output logic [3:0]             sticky_flags,
    input  logic                   clr_flags,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] vpipe;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [31:0]        mem_data  [DEPTH];
    logic [4:0]         mem_flags [DEPTH];
    logic [SW-1:0]      inflight;
    logic               acc;
    logic               push;
    logic               pop;
    logic [7:0]         c_exp;
    logic [22:0]        c_frac;
    logic [4:0]         c_flags;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight = inflight + SW'(vpipe[i]);
    end

    // Credits cover both buffered and in-flight results, so a push never meets a full FIFO.
    assign in_ready  = (SW'(count) + inflight) < SW'(DEPTH);
    assign acc       = in_valid & in_ready;
    assign push      = vpipe[LATENCY-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_flags = mem_flags[rd_ptr];

    assign c_exp   = c_in[30:23];
    assign c_frac  = c_in[22:0];
    assign c_flags = {(c_exp == 8'hFF) && (c_frac != '0),
                      (c_exp == 8'hFF) && (c_frac == '0),
                      (c_exp == 8'h00) && (c_frac == '0),
                      (c_exp == 8'h00) && (c_frac != '0),
                      c_in[31]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            vpipe <= (vpipe << 1) | LATENCY'(acc);
            if (push) begin
                mem_data[wr_ptr]  <= c_in;
                mem_flags[wr_ptr] <= c_flags;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FMUL_STICKY_FLAGS_EN
    // A clear in the same cycle as a push drops that push's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flags <= '0;
        else if (clr_flags)
            sticky_flags <= '0;
        else if (push)
            sticky_flags <= sticky_flags | c_flags[4:1];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmul_result_stage.sv
`default_nettype none
// Testbench for fmul_result_stage: multiplier delay-line model driving c_in,
// queue-based reference model compared every cycle, plus directed literal checks.
module tb_fmul_result_stage;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] c_in;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic [3:0]  count;
`ifdef FMUL_STICKY_FLAGS_EN
    logic [3:0]  sticky_flags;
    logic        clr_flags = 1'b0;
`endif
    logic [31:0] issue_val = '0;
    logic [31:0] mpipe [LATENCY] = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fmul_result_stage #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .c_in         (c_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
`ifdef FMUL_STICKY_FLAGS_EN
        .sticky_flags (sticky_flags),
        .clr_flags    (clr_flags),
`endif
        .count        (count)
    );

    // Upstream multiplier: free-running delay line, never reset.
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--)
            mpipe[i] <= mpipe[i-1];
        mpipe[0] <= issue_val;
    end
    assign c_in = mpipe[LATENCY-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] classify(input logic [31:0] v);
        logic is_max, is_min, frac_nz;
        is_max  = (v[30:23] == 8'hFF);
        is_min  = (v[30:23] == 8'h00);
        frac_nz = (v[22:0] != 23'h0);
        return {is_max & frac_nz, is_max & ~frac_nz, is_min & ~frac_nz, is_min & frac_nz, v[31]};
    endfunction

    // Reference model: pending issues carry the cycle their product becomes due.
    typedef struct {
        logic [31:0] v;
        int          due;
    } pend_t;
    pend_t       pq[$];
    logic [31:0] fq[$];
    int          cyc     = 0;
    bit          m_ready = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        bit do_pop;
        if (!rst_n) begin
            pq.delete();
            fq.delete();
            m_ready = 1'b1;
        end else begin
            do_pop = (fq.size() != 0) && out_ready;
            if (pq.size() != 0 && pq[0].due == cyc) begin
                checks++;
                if (count == 4'(DEPTH) && !(out_valid && out_ready)) begin
                    failures++;
                    $display("FAIL push_into_full: count=%0d at %0t", count, $time);
                end
            end
            if (do_pop)
                void'(fq.pop_front());
            if (pq.size() != 0 && pq[0].due == cyc) begin
                fq.push_back(pq[0].v);
                void'(pq.pop_front());
            end
            if (in_valid && m_ready)
                pq.push_back('{issue_val, cyc + LATENCY});
            m_ready = (fq.size() + pq.size()) < DEPTH;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_ready);
            chk("count", count, fq.size());
            chk("out_valid", out_valid, fq.size() != 0);
            if (fq.size() != 0) begin
                chk("out_data", out_data, fq[0]);
                chk("out_flags", out_flags, classify(fq[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_flags"}, out_flags, 0);
`ifdef FMUL_STICKY_FLAGS_EN
        chk({tag, "_sticky"}, sticky_flags, 0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    logic [31:0] b2b_vals  [5] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h0001A000, 32'hD6210F00};
    logic [4:0]  b2b_flags [5] = '{5'b01000, 5'b10000, 5'b00100, 5'b00010, 5'b00001};

    initial begin : stim
        int n, maxc, nacc, np, nv;
        #1;
        chk_reset_vals("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single issue: first visible after the LATENCY-th edge following accept
        out_ready = 1'b1;
        issue_val = 32'h42800000;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("single_early", out_valid, 0);
        @(negedge clk);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 32'h42800000);
        chk("single_flags", out_flags, 5'b00000);
        repeat (3) tick();

        // Back-to-back special values, consumed as they appear
        for (int i = 0; i < 5; i++) begin
            issue_val = b2b_vals[i];
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        maxc = 0;
        repeat (12) begin
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
            if (out_valid) begin
                if (n < 5) begin
                    chk("b2b_data", out_data, b2b_vals[n]);
                    chk("b2b_flags", out_flags, b2b_flags[n]);
                end
                n++;
            end
        end
        chk("b2b_n", n, 5);
        chk("b2b_maxcount", maxc, 1);
        tick();

        // Fill with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            issue_val = 32'h3F800000 + i;
            @(negedge clk);
            if (in_ready) nacc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("fill_accepts", nacc, 8);
        chk("fill_count", count, 8);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_head", out_data, 32'h3F800000);

        // Drain while streaming new issues with intermittent consumer stalls
        np = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue_val = 32'h40000000 + i;
            out_ready = (i % 3 != 2);
            @(negedge clk);
            if (out_valid && out_ready && np < 8) begin
                chk("drain_order", out_data, 32'h3F800000 + np);
                np++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("drain_n", np, 8);
        chk("drain_empty", count, 0);

        // Reset with 2 buffered and 3 in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_val = 32'h41000000 + i;
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_rst_count", count, 2);
        chk("pre_rst_in_ready", in_ready, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("post_rst_quiet", nv, 0);
        tick();

`ifdef FMUL_STICKY_FLAGS_EN
        issue_val = 32'h7F800000;
        in_valid  = 1'b1;
        tick();
        issue_val = 32'h7FC00000;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("sticky_set", sticky_flags, 4'b1100);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("sticky_clr", sticky_flags, 4'b0000);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
